debug_seq_bcd_conv: RTL and testbench
=====================================

Name: debug_seq_bcd_conv

Overview:
Converts the packed bank of sign-extended two's-complement debug sequences into per-sequence BCD digit strings for the on-screen font renderer. It is the decode end of the debug-variable path: upstream logic packs signed values into SEQ_LEN-bit slots, and this block turns them into a sign digit plus magnitude digits. Conversion is iterative double-dabble, one sequence at a time, started by a frame-rate pulse. Results are committed atomically, so the display never shows a half-updated bank.

Parameters:
SEQ_LEN, 20, width of each packed signed sequence slot
SEQ_NUM, 6, number of sequences in the bank
SEQ_DIGITS, 6, output digits per sequence: 1 sign digit plus (SEQ_DIGITS-1) magnitude digits
INT_DIGITS, SEQ_LEN/3+1, internal BCD digits in the shift register (7 by default; 10^7 > 2^20)

Ports:
sys_clk  in  1  system clock
sys_rst_n  in  1  asynchronous active-low reset
start  in  1  single-cycle conversion request (e.g. vsync edge)
seq_in  in  SEQ_LEN*SEQ_NUM  packed signed sequences; slot k = seq_in[k*SEQ_LEN +: SEQ_LEN]
busy  out  1  high while a conversion is in progress
done  out  1  one-cycle pulse when a new bank is committed
bcd_out  out  SEQ_NUM*SEQ_DIGITS*4  slot k = bcd_out[k*SEQ_DIGITS*4 +: SEQ_DIGITS*4]; top nibble = sign, then digits MS to LS
ovf  out  SEQ_NUM  per-sequence saturation flag, committed with bcd_out

Behaviour:
- Reset is sys_rst_n, asynchronous, active-low; clock is sys_clk.
- Reset values: busy=0, done=0, ovf=0. Every bcd_out slot = sign 4'hF followed by all-zero digits (displays +0). FSM goes to IDLE, index=0. Reset asserted mid-conversion discards all staged results.
- Sign encoding: 4'hA = minus, 4'hF = blank (positive or zero). Digits 0-9 use values 4'h0-4'h9.
- FSM states: IDLE, ABS, SHIFT, STORE, COMMIT.
- IDLE: when start=1, snapshot all of seq_in into an internal register, set index=0, set busy=1, go to ABS. While busy, start is ignored; requests are not queued.
- ABS (1 cycle): record sign = MSB of the snapshot slot. Magnitude = SEQ_LEN-bit two's-complement absolute value; -2^(SEQ_LEN-1) yields 2^(SEQ_LEN-1) unsigned. Clear the BCD register and set bitcnt=0. Go to SHIFT.
- SHIFT (exactly SEQ_LEN cycles): add 3 to every internal BCD digit that is >=5, then shift {bcd,mag} left by 1. After bitcnt reaches SEQ_LEN-1, go to STORE.
- STORE (1 cycle):
  - If any internal digit at position >= SEQ_DIGITS-1 is nonzero, force the magnitude digits to all 9s and set the staged ovf[index]=1.
  - Write the sign nibble and magnitude digits into the staging buffer slot index.
  - A negative value whose magnitude is 0 cannot occur; a zero result always gets sign 4'hF.
  - If index==SEQ_NUM-1, go to COMMIT; otherwise increment index and go to ABS.
- COMMIT (1 cycle): on the exit edge, copy the staging buffer to bcd_out and ovf, pulse done=1 for one cycle, clear busy, return to IDLE.
- Latency: done and the new bcd_out appear SEQ_NUM*(SEQ_LEN+2)+1 edges after the edge that accepted start (133 with defaults).
- A start arriving in the same cycle that done is high is accepted, because the FSM is already in IDLE.
- bcd_out is stable between commits; seq_in changes during a conversion have no effect.

Optional Feature:
DEBUG_SEQ_LEADING_BLANK_EN
- Defined: in STORE, magnitude digits above the most significant nonzero digit are replaced with 4'hF (blank). The least significant digit is always shown, so zero displays as blank...blank 0. The sign digit stays in the top nibble; it does not move next to the number. Saturated values are unaffected (all 9s).
- Undefined: leading zeros are kept as 4'h0.

Test Plan:
- Reset, then read outputs without start -> every slot = 24'hF00000, busy=0, done=0, ovf=0.
- Slot0=20'd0, slot1=20'hFFFFF (-1), slot2=20'd65536, pulse start -> after 133 cycles done=1 for 1 cycle; slot0=24'hF00000, slot1=24'hA00001, slot2=24'hF65536, ovf=0.
- Slot3=20'h80000 (-524288), slot4=20'd123456 -> slot3=24'hA99999, slot4=24'hF99999, ovf[3]=1, ovf[4]=1.
- Pulse start, then pulse start again at cycle +10 and change seq_in at cycle +20 -> exactly one done pulse at +133, and results reflect the first snapshot.
- Assert sys_rst_n low at cycle +50 of a conversion, release, pulse start with new data -> busy drops immediately, outputs return to reset values, and the next done at +133 shows only the new data.
- With DEBUG_SEQ_LEADING_BLANK_EN defined, slot0=20'd42 and slot1=20'hFFFF9 (-7) -> slot0=24'hFFFF42, slot1=24'hAFFFF7.

Source files
------------

// File: rtl/debug_seq_bcd_conv.sv
// rtl/debug_seq_bcd_conv.sv - iterative double-dabble of packed signed debug sequences into sign+BCD strings
// Define DEBUG_SEQ_LEADING_BLANK_EN to blank leading zero magnitude digits.
module debug_seq_bcd_conv #(
  parameter int SEQ_LEN    = 20,
  parameter int SEQ_NUM    = 6,
  parameter int SEQ_DIGITS = 6,
  parameter int INT_DIGITS = SEQ_LEN/3+1
) (
  input  logic                           sys_clk,
  input  logic                           sys_rst_n,
  input  logic                           start,
  input  logic [SEQ_LEN*SEQ_NUM-1:0]     seq_in,
  output logic                           busy,
  output logic                           done,
  output logic [SEQ_NUM*SEQ_DIGITS*4-1:0] bcd_out,
  output logic [SEQ_NUM-1:0]             ovf
);

  localparam int SLOT_W     = SEQ_DIGITS*4;
  localparam int MAG_DIGITS = SEQ_DIGITS-1;
  localparam int BCD_W      = INT_DIGITS*4;
  localparam int IDX_W      = (SEQ_NUM > 1) ? $clog2(SEQ_NUM) : 1;
  localparam int CNT_W      = $clog2(SEQ_LEN);
  localparam logic [3:0] SIGN_MINUS = 4'hA;
  localparam logic [3:0] SIGN_BLANK = 4'hF;
  localparam logic [SLOT_W-1:0] RST_SLOT = {SIGN_BLANK, {(MAG_DIGITS*4){1'b0}}};

  typedef enum logic [2:0] {IDLE, ABS, SHIFT, STORE, COMMIT} state_t;

  state_t                      state;
  logic [SEQ_LEN*SEQ_NUM-1:0]  snap;
  logic [IDX_W-1:0]            index;
  logic [CNT_W-1:0]            bitcnt;
  logic                        neg;
  logic [SEQ_LEN-1:0]          mag;
  logic [BCD_W-1:0]            bcd;
  logic [SEQ_NUM*SLOT_W-1:0]   stage_bcd;
  logic [SEQ_NUM-1:0]          stage_ovf;

  logic [SEQ_LEN-1:0]          cur_slot;
  logic [BCD_W-1:0]            bcd_adj;
  logic [BCD_W+SEQ_LEN-1:0]    shifted;
  logic                        sat;
  logic [MAG_DIGITS*4-1:0]     mag_digits;
  logic [SLOT_W-1:0]           store_word;
`ifdef DEBUG_SEQ_LEADING_BLANK_EN
  logic                        seen;
`endif

  assign cur_slot = snap[index*SEQ_LEN +: SEQ_LEN];

  always_comb begin
    bcd_adj = bcd;
    for (int d = 0; d < INT_DIGITS; d++) begin
      if (bcd[d*4 +: 4] >= 4'd5) bcd_adj[d*4 +: 4] = bcd[d*4 +: 4] + 4'd3;
    end
  end

  assign shifted = {bcd_adj, mag} << 1;

  // Digits beyond the displayable range mean the value saturates to all 9s.
  always_comb begin
    sat = 1'b0;
    for (int d = MAG_DIGITS; d < INT_DIGITS; d++) begin
      if (bcd[d*4 +: 4] != 4'd0) sat = 1'b1;
    end
    mag_digits = sat ? {MAG_DIGITS{4'h9}} : bcd[MAG_DIGITS*4-1:0];
`ifdef DEBUG_SEQ_LEADING_BLANK_EN
    seen = 1'b0;
    for (int d = MAG_DIGITS-1; d > 0; d--) begin
      if (mag_digits[d*4 +: 4] != 4'd0) seen = 1'b1;
      if (!seen) mag_digits[d*4 +: 4] = 4'hF;
    end
`endif
    store_word = {((neg && (bcd != '0)) ? SIGN_MINUS : SIGN_BLANK), mag_digits};
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state     <= IDLE;
      snap      <= '0;
      index     <= '0;
      bitcnt    <= '0;
      neg       <= 1'b0;
      mag       <= '0;
      bcd       <= '0;
      stage_bcd <= {SEQ_NUM{RST_SLOT}};
      stage_ovf <= '0;
      bcd_out   <= {SEQ_NUM{RST_SLOT}};
      ovf       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            snap  <= seq_in;
            index <= '0;
            busy  <= 1'b1;
            state <= ABS;
          end
        end
        ABS: begin
          neg    <= cur_slot[SEQ_LEN-1];
          mag    <= cur_slot[SEQ_LEN-1] ? -cur_slot : cur_slot;
          bcd    <= '0;
          bitcnt <= '0;
          state  <= SHIFT;
        end
        SHIFT: begin
          {bcd, mag} <= shifted;
          bitcnt     <= bitcnt + CNT_W'(1);
          if (bitcnt == CNT_W'(SEQ_LEN-1)) state <= STORE;
        end
        STORE: begin
          stage_bcd[index*SLOT_W +: SLOT_W] <= store_word;
          stage_ovf[index]                  <= sat;
          if (index == IDX_W'(SEQ_NUM-1)) begin
            state <= COMMIT;
          end else begin
            index <= index + IDX_W'(1);
            state <= ABS;
          end
        end
        COMMIT: begin
          bcd_out <= stage_bcd;
          ovf     <= stage_ovf;
          done    <= 1'b1;
          busy    <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_debug_seq_bcd_conv.sv
// tb/tb_debug_seq_bcd_conv.sv - directed bench for debug_seq_bcd_conv
// Expected values follow DEBUG_SEQ_LEADING_BLANK_EN when defined.
module tb_debug_seq_bcd_conv;

  logic         sys_clk   = 1'b0;
  logic         sys_rst_n = 1'b0;
  logic         start     = 1'b0;
  logic [119:0] seq_in    = '0;
  logic         busy;
  logic         done;
  logic [143:0] bcd_out;
  logic [5:0]   ovf;

  int checks   = 0;
  int failures = 0;
  int ndone;
  int first_done;

  localparam logic [143:0] RST_BCD = {6{24'hF00000}};

  localparam logic [119:0] SEQ1 = {20'd99999, 20'd123456, 20'h80000, 20'd65536, 20'hFFFFF, 20'd0};
  localparam logic [119:0] SEQ2 = {20'd12345, 20'hFFF9C, 20'h7FFFF, 20'd100000, 20'hFFFF9, 20'd42};
  localparam logic [119:0] SEQB = {6{20'd1}};
  localparam logic [119:0] SEQC = {100'd0, 20'd7};
  localparam logic [5:0]   OVF1 = 6'b011000;
  localparam logic [5:0]   OVF2 = 6'b001100;

`ifdef DEBUG_SEQ_LEADING_BLANK_EN
  localparam logic [143:0] EXP1 = {24'hF99999, 24'hF99999, 24'hA99999, 24'hF65536, 24'hAFFFF1, 24'hFFFFF0};
  localparam logic [143:0] EXP2 = {24'hF12345, 24'hAFF100, 24'hF99999, 24'hF99999, 24'hAFFFF7, 24'hFFFF42};
  localparam logic [143:0] EXPB = {6{24'hFFFFF1}};
  localparam logic [143:0] EXPC = {{5{24'hFFFFF0}}, 24'hFFFFF7};
`else
  localparam logic [143:0] EXP1 = {24'hF99999, 24'hF99999, 24'hA99999, 24'hF65536, 24'hA00001, 24'hF00000};
  localparam logic [143:0] EXP2 = {24'hF12345, 24'hA00100, 24'hF99999, 24'hF99999, 24'hA00007, 24'hF00042};
  localparam logic [143:0] EXPB = {6{24'hF00001}};
  localparam logic [143:0] EXPC = {{5{24'hF00000}}, 24'hF00007};
`endif

  debug_seq_bcd_conv dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .start     (start),
    .seq_in    (seq_in),
    .busy      (busy),
    .done      (done),
    .bcd_out   (bcd_out),
    .ovf       (ovf)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string tag, input logic [143:0] obs, input logic [143:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge sys_clk); #1;
    start = 1'b0;
  endtask

  // Cycle n is sampled 1 ns after the n-th edge following the accepting edge.
  task automatic run(input int base, input int ncyc, input int restart_at, input int change_at,
                     input logic [119:0] new_seq, output int nd, output int fd);
    nd = 0;
    fd = -1;
    for (int n = base + 1; n <= base + ncyc; n++) begin
      @(posedge sys_clk); #1;
      if (done) begin
        nd++;
        if (fd < 0) fd = n;
      end
      start = (n == restart_at - 1);
      if (n == change_at) seq_in = new_seq;
    end
    start = 1'b0;
  endtask

  initial begin
    repeat (3) @(posedge sys_clk);
    #1 sys_rst_n = 1'b1;
    @(posedge sys_clk); #1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_ovf", ovf, 6'd0);
    chk("rst_bcd", bcd_out, RST_BCD);

    seq_in = SEQ1;
    pulse_start();
    chk("c1_busy_hi", busy, 1'b1);
    run(0, 140, 0, 0, '0, ndone, first_done);
    chk("c1_done_cnt", ndone, 1);
    chk("c1_latency", first_done, 133);
    chk("c1_bcd", bcd_out, EXP1);
    chk("c1_ovf", ovf, OVF1);
    chk("c1_busy_lo", busy, 1'b0);

    seq_in = SEQ2;
    pulse_start();
    run(0, 60, 10, 20, SEQB, ndone, first_done);
    chk("c2_no_early_done", ndone, 0);
    chk("c2_bcd_stable", bcd_out, EXP1);
    run(60, 80, 0, 0, '0, ndone, first_done);
    chk("c2_done_cnt", ndone, 1);
    chk("c2_latency", first_done, 133);
    chk("c2_bcd", bcd_out, EXP2);
    chk("c2_ovf", ovf, OVF2);

    pulse_start();
    run(0, 133, 0, 0, '0, ndone, first_done);
    chk("c3_latency", first_done, 133);
    chk("c3_done_hi", done, 1'b1);
    chk("c3_bcd", bcd_out, EXPB);
    chk("c3_ovf", ovf, 6'd0);
    pulse_start();
    chk("c4_accept_on_done", busy, 1'b1);
    chk("c4_done_pulse", done, 1'b0);

    run(0, 49, 0, 0, '0, ndone, first_done);
    sys_rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_done", done, 1'b0);
    chk("mid_rst_ovf", ovf, 6'd0);
    chk("mid_rst_bcd", bcd_out, RST_BCD);
    #2 sys_rst_n = 1'b1;
    seq_in = SEQC;
    @(posedge sys_clk); #1;
    chk("post_rst_idle", busy, 1'b0);
    pulse_start();
    run(0, 140, 0, 0, '0, ndone, first_done);
    chk("c5_done_cnt", ndone, 1);
    chk("c5_latency", first_done, 133);
    chk("c5_bcd", bcd_out, EXPC);
    chk("c5_ovf", ovf, 6'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
